// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable serial sequence detector.
package seq_det_pkg;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 8;

  localparam logic OVERLAP     = 1'b1;
  localparam logic NON_OVERLAP = 1'b0;

  // Right-aligned mask with the low `len` bits set.
  function automatic logic [31:0] len_mask(input logic [31:0] len);
    if (len >= 32'd32) return '1;
    return (32'd1 << len) - 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc_i, holds at all-ones, never wraps.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/param_seq_detector.sv
// Runtime-programmable serial bit-sequence detector with zero-latency Mealy det.
// Define SEQ_DET_MATCH_CNT_EN to build the saturating match counter; otherwise match_cnt is 0.
module param_seq_detector
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN     = DEF_MAX_LEN,
  parameter int                 LEN_W       = $clog2(MAX_LEN + 1),
  parameter int                 CNT_W       = DEF_CNT_W,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(9),
  parameter logic [LEN_W-1:0]   DEF_LEN     = LEN_W'(4),
  parameter logic               DEF_OVERLAP = OVERLAP
) (
  input  logic               clck,
  input  logic               rst_n,
  input  logic               in,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               det,
  output logic [LEN_W-1:0]   fill,
  output logic [CNT_W-1:0]   match_cnt
);

  logic [MAX_LEN-1:0] hist_q, hist_d, pat_q, pat_d, hist_nxt;
  logic [LEN_W-1:0]   fill_q, fill_d, len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               len_ok, fill_ok, bits_eq, match;

  always_comb begin
    hist_nxt = {hist_q[MAX_LEN-2:0], in};
    len_ok   = (len_q != '0) && (len_q <= LEN_W'(MAX_LEN));
    fill_ok  = ((LEN_W+1)'(fill_q) + (LEN_W+1)'(1)) >= (LEN_W+1)'(len_q);
    bits_eq  = ((32'(hist_nxt ^ pat_q)) & len_mask(32'(len_q))) == 32'd0;
    match    = in_valid & ~cfg_load & len_ok & fill_ok & bits_eq;
  end

  // Reset gating keeps det quiet while rst_n is held, whatever the defaults are.
  assign det  = match & rst_n;
  assign fill = fill_q;

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    if (cfg_load) begin
      pat_d  = cfg_pattern;
      len_d  = cfg_len;
      ovl_d  = cfg_overlap;
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d = hist_nxt;
      if (match && (ovl_q == NON_OVERLAP)) fill_d = '0;
      else if (fill_q != LEN_W'(MAX_LEN))  fill_d = fill_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clck or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= DEF_PATTERN;
      len_q  <= DEF_LEN;
      ovl_q  <= DEF_OVERLAP;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
    end
  end

`ifdef SEQ_DET_MATCH_CNT_EN
  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk   (clck),
    .rst_n (rst_n),
    .inc_i (det),
    .cnt_o (match_cnt)
  );
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_param_seq_detector.sv
// Randomized and directed checks of param_seq_detector against a bit-queue reference model.
module tb_param_seq_detector;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int CNT_W   = 2;

  logic               clck = 1'b0;
  logic               rst_n = 1'b0;
  logic               in = 1'b0, in_valid = 1'b0, cfg_load = 1'b0, cfg_overlap = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               det;
  logic [LEN_W-1:0]   fill;
  logic [CNT_W-1:0]   match_cnt;

  param_seq_detector #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clck(clck), .rst_n(rst_n), .in(in), .in_valid(in_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .det(det), .fill(fill), .match_cnt(match_cnt)
  );

  always #5 clck = ~clck;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: valid bits received since the last clear, oldest first.
  bit   m_q[$];
  logic [MAX_LEN-1:0] m_pat;
  int   m_len;
  bit   m_ovl;
  int   m_cnt;

  task automatic model_reset();
    m_q.delete();
    m_pat = 8'b0000_1001;
    m_len = 4;
    m_ovl = 1'b1;
    m_cnt = 0;
  endtask

  // Would appending bit b complete the programmed pattern (MSB of pattern first)?
  function automatic bit model_match(input bit b);
    bit s[$];
    int n;
    if (m_len < 1 || m_len > MAX_LEN) return 1'b0;
    s = m_q;
    s.push_back(b);
    n = s.size();
    if (n < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++)
      if (s[n - m_len + i] != m_pat[m_len - 1 - i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int exp_cnt();
`ifdef SEQ_DET_MATCH_CNT_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  int n_det = 0;

  task automatic do_cycle(input bit v, input bit b, input bit ld,
                          input logic [7:0] pat, input int len, input bit ovl);
    bit exp_det;
    in_valid = v; in = b; cfg_load = ld;
    cfg_pattern = pat; cfg_len = LEN_W'(len); cfg_overlap = ovl;
    exp_det = v && !ld && model_match(b);
    @(negedge clck);
    chk("det", int'(det), int'(exp_det));
    chk("fill", int'(fill), (m_q.size() > MAX_LEN) ? MAX_LEN : m_q.size());
    chk("match_cnt", int'(match_cnt), exp_cnt());
    if (exp_det) n_det++;
    @(posedge clck);
    if (ld) begin
      m_pat = pat; m_len = len; m_ovl = ovl;
      m_q.delete();
    end else if (v) begin
      m_q.push_back(b);
      while (m_q.size() > MAX_LEN) void'(m_q.pop_front());
      if (exp_det) begin
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (!m_ovl) m_q.delete();
      end
    end
    #1;
  endtask

  task automatic feed(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) do_cycle(1'b1, bits[i], 1'b0, '0, 0, 1'b0);
  endtask

  initial begin
    int det_before;
    model_reset();
    // Held in reset with a live 1 on the input.
    in_valid = 1'b1; in = 1'b1;
    #12;
    chk("rst_det", int'(det), 0);
    chk("rst_fill", int'(fill), 0);
    chk("rst_cnt", int'(match_cnt), 0);
    @(negedge clck); rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clck); #1;

    // Defaults, overlapping: 1001001 hits on bits 4 and 7.
    det_before = n_det;
    feed(32'b1001001, 7);
    chk("t1_hits", n_det - det_before, 2);

    // Non-overlap: only bit 4 hits.
    do_cycle(1'b0, 1'b0, 1'b1, 8'b1001, 4, 1'b0);
    det_before = n_det;
    feed(32'b1001001, 7);
    chk("t2_hits", n_det - det_before, 1);

    // Idle gaps (with in=1) inside a sequence.
    do_cycle(1'b0, 1'b0, 1'b1, 8'b1001, 4, 1'b1);
    det_before = n_det;
    do_cycle(1'b1, 1'b1, 1'b0, '0, 0, 1'b0);
    do_cycle(1'b0, 1'b1, 1'b0, '0, 0, 1'b0);
    do_cycle(1'b1, 1'b0, 1'b0, '0, 0, 1'b0);
    do_cycle(1'b0, 1'b1, 1'b0, '0, 0, 1'b0);
    do_cycle(1'b0, 1'b1, 1'b0, '0, 0, 1'b0);
    do_cycle(1'b1, 1'b0, 1'b0, '0, 0, 1'b0);
    do_cycle(1'b1, 1'b1, 1'b0, '0, 0, 1'b0);
    chk("t3_hits", n_det - det_before, 1);

    // Asynchronous reset between edges loses partial progress.
    feed(32'b100, 3);
    in_valid = 1'b0;
    @(negedge clck); #1 rst_n = 1'b0;
    #1;
    chk("t4_async_fill", int'(fill), 0);
    rst_n = 1'b1;
    model_reset();
    @(posedge clck); #1;
    det_before = n_det;
    feed(32'b1, 1);
    chk("t4_hits", n_det - det_before, 0);
    chk("t4_fill", int'(fill), 1);

    // Load with a simultaneous valid bit, then 110.
    do_cycle(1'b1, 1'b1, 1'b1, 8'b110, 3, 1'b1);
    chk("t5_fill_after_load", int'(fill), 0);
    det_before = n_det;
    feed(32'b110, 3);
    chk("t5_hits", n_det - det_before, 1);
    do_cycle(1'b0, 1'b0, 1'b1, 8'b0, 0, 1'b1);
    det_before = n_det;
    for (int i = 0; i < 20; i++) do_cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, '0, 0, 1'b0);
    chk("t5_len0_hits", n_det - det_before, 0);

    // Five overlapping matches drive the counter to saturation.
    do_cycle(1'b0, 1'b0, 1'b1, 8'b1001, 4, 1'b1);
    det_before = n_det;
    feed(32'b1001001001001001, 16);
    chk("t6_hits", n_det - det_before, 5);
    chk("t6_cnt", int'(match_cnt), exp_cnt());

    // Random traffic with occasional reconfiguration, including illegal lengths.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0)
        do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
                 8'($urandom), ($urandom_range(0, 5) == 0) ? $urandom_range(0, 15)
                                                           : $urandom_range(1, 3),
                 1'($urandom_range(0, 1)));
      else
        do_cycle(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0,
                 8'($urandom), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/param_seq_detector.md
Name: param_seq_detector

Overview:
- Next-generation serial bit-sequence detector. Replaces the fixed 4-bit pattern FSMs with one runtime-programmable block.
- Pattern value, pattern length (1..MAX_LEN) and overlap/non-overlap mode are all configurable.
- Mealy detect output, optional saturating match counter.
- Sits after any serial bit source; `in_valid` qualifies each bit.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits (≥2).
- LEN_W, $clog2(MAX_LEN+1): width of length fields.
- CNT_W, 8: match counter width.
- DEF_PATTERN, 8'b0000_1001: reset pattern (right-aligned).
- DEF_LEN, 4: reset pattern length.
- DEF_OVERLAP, 1: reset mode (1 = overlapping).

Ports:
- clck, input, 1: clock, rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- in, input, 1: serial data bit.
- in_valid, input, 1: `in` is consumed this cycle when high.
- cfg_load, input, 1: load configuration.
- cfg_pattern, input, MAX_LEN: new pattern, right-aligned.
- cfg_len, input, LEN_W: new pattern length.
- cfg_overlap, input, 1: new mode.
- det, output, 1: Mealy match pulse.
- fill, output, LEN_W: number of valid history bits.
- match_cnt, output, CNT_W: match count.

Behaviour:
- **Clock and reset:** one clock `clck`. Reset is asynchronous and active-low on `rst_n`.
- **Reset values:**
  - hist = 0, fill = 0, match_cnt = 0.
  - Shadow config = DEF_PATTERN / DEF_LEN / DEF_OVERLAP.
  - det = 0 while rst_n is low, regardless of `in`.
- **Bit order:** cfg_pattern[len-1] is received first; cfg_pattern[0] is received last.
- **History:** hist is a MAX_LEN shift register. `hist_nxt = {hist[MAX_LEN-2:0], in}`. It updates only when in_valid=1.
- **Fill:** fill increments on each valid bit and saturates at MAX_LEN.
- **Match condition (combinational, same cycle as the last bit, zero latency):**
  - `match = in_valid & ~cfg_load & (fill+1 >= len) & ((hist_nxt ^ pattern) & mask) == 0`
  - `mask = (1<<len)-1`.
  - det = match.
- **Illegal lengths:** len == 0 or len > MAX_LEN means match is always 0. Such a length is accepted into the shadow registers but never detects.
- **After a match:**
  - Overlap mode: hist and fill update normally.
  - Non-overlap mode: fill is cleared to 0 on the clock edge. hist still shifts, but is don't-care because fill gates matching.
- **in_valid = 0:** hist, fill and counter hold; det = 0. Idle gaps do not break a sequence in progress.
- **cfg_load = 1:**
  - Shadow registers take the cfg_* values on that edge.
  - hist and fill clear to 0.
  - A bit presented in the same cycle is discarded, and det = 0 (cfg_load wins).
  - match_cnt is not cleared.
- **Matching uses only the shadow config;** cfg_* inputs are ignored except when cfg_load = 1.
- **Reset mid-sequence:** all partial progress is lost. Matching restarts from fill = 0 with the default config.
- **Counter (when enabled):** match_cnt increments on each det and saturates at 2^CNT_W − 1. It never wraps.
- **State view:** fill/hist replaces the explicit A/B/C/D encoding. fill = k corresponds to the "k bits seen" state, capped at MAX_LEN.

Optional Feature:
- Macro: SEQ_DET_MATCH_CNT_EN.
- Defined: saturating match_cnt register present, as described above.
- Undefined: no counter flops; match_cnt is tied to 0. The port stays in the interface so integration is unchanged.

Decomposition:
- Shared package seq_det_pkg holds:
  - localparams DEF_MAX_LEN, DEF_CNT_W.
  - Mode constants OVERLAP = 1'b1, NON_OVERLAP = 1'b0.
  - Function len_mask(len) returning the right-aligned mask.
- One natural sub-module: sat_counter (CNT_W, increment enable, async active-low reset). It is instantiated only under SEQ_DET_MATCH_CNT_EN.
- Match compare and history stay in the top module.

Test Plan:
1. Defaults (1001, len 4, overlap), valid stream 1,0,0,1,0,0,1 → det high on bits 4 and 7; match_cnt = 2.
2. cfg_load {1001, len 4, overlap = 0}, same stream → det high on bit 4 only (bit 7 has fill = 3); match_cnt = 1.
3. Valid bits 1,0,0 with idle in_valid = 0 cycles between them, then 1 → det on the 4th valid bit. det stays 0 on idle cycles even when in = 1.
4. Stream 1,0,0, then pulse rst_n low asynchronously between clock edges, then 1 → no det; fill = 1 after the final bit.
5. cfg_load {pattern 8'b110, len 3} asserted together with in_valid = 1, in = 1 → det = 0 and bit discarded. Then 1,1,0 → det on the 0. Also load len 0 → no det for any stream.
6. CNT_W = 2 with SEQ_DET_MATCH_CNT_EN, overlap, stream producing 5 matches (e.g. 1001001001001001) → match_cnt saturates at 3. With the macro undefined → match_cnt stays 0.
